// File: rtl/cpu_jtag_debug_pkg.sv
// Shared constants and types for the JTAG debug OCI memory controller:
// jdo bus field positions, control register bit positions and the CPU read FSM encoding.
package cpu_jtag_debug_pkg;

  localparam int JDO_W           = 38;
  localparam int JDO_RD_BIT      = 35;
  localparam int JDO_CLR_BIT     = 34;
  localparam int JDO_ADDR_LSB    = 17;
  localparam int JDO_WDATA_MSB   = 34;
  localparam int JDO_WDATA_LSB   = 3;
  localparam int CTRL_READY_BIT  = 0;
  localparam int CTRL_ERROR_BIT  = 1;
  localparam int JTAG_RD_LATENCY = 2;

  typedef enum logic {
    CPU_IDLE    = 1'b0,
    CPU_RD_WAIT = 1'b1
  } cpu_rd_state_e;

endpackage

// File: rtl/cpu_jtag_debug_ocimem_ram.sv
// Single-port 2**ADDR_W x 32 debug RAM, synchronous read, byte-lane writes.
// Contents have no reset; the read register only updates on read cycles.
module cpu_jtag_debug_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/cpu_jtag_debug_ocimem_ctrl.sv
// OCI debug memory controller: JTAG-side MonAReg/MonDReg access, CPU Avalon-MM slave,
// RAM port arbitration (JTAG first) and the CPU-set / JTAG-cleared monitor flags.
module cpu_jtag_debug_ocimem_ctrl
  import cpu_jtag_debug_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W:0]   avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W-1:0] dbg_mon_a_reg,
  output cpu_rd_state_e     dbg_rd_state
);

  logic [ADDR_W-1:0] mon_a_reg;
  logic              jrd_pend;
  logic              jrd_dly;
  logic              jwr_pend;
  logic [31:0]       jwr_data;
  cpu_rd_state_e     rd_state;
  logic              rd_is_ctrl;
  logic [1:0]        ctrl_q;

  logic              ram_en;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  logic jtag_busy, ctrl_sel, cpu_wr, cpu_rd, ram_wr_ok, rd_issue;
  logic set_ready, set_error, clr_mon;
  logic take_a, take_n;
  logic unused_ok;

  assign take_a    = take_action_ocimem_a & ~take_action_ocimem_b;
  assign take_n    = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
  assign jtag_busy = jrd_pend | jwr_pend;
  assign ctrl_sel  = avs_address[ADDR_W];
  assign cpu_wr    = avs_write;
  assign cpu_rd    = avs_read & ~avs_write;
  assign ram_wr_ok = cpu_wr & ~ctrl_sel & ~jtag_busy;
  assign rd_issue  = cpu_rd & (rd_state == CPU_IDLE) & (ctrl_sel | ~jtag_busy);
  assign set_ready = cpu_wr & ctrl_sel & avs_writedata[CTRL_READY_BIT];
  assign set_error = cpu_wr & ctrl_sel & avs_writedata[CTRL_ERROR_BIT];
  assign clr_mon   = take_a & jdo[JDO_CLR_BIT];
  assign unused_ok = &{1'b0, jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_WDATA_LSB-1:0]};

  // RAM port owner: a pending JTAG op always wins, otherwise the CPU gets the cycle.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = 4'h0;
    ram_addr  = mon_a_reg;
    ram_wdata = jwr_data;
    if (jwr_pend) begin
      ram_en = 1'b1;
      ram_we = 1'b1;
      ram_be = 4'hF;
    end else if (jrd_pend) begin
      ram_en = 1'b1;
    end else if (ram_wr_ok) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_be    = avs_byteenable;
      ram_addr  = avs_address[ADDR_W-1:0];
      ram_wdata = avs_writedata;
    end else if (rd_issue && !ctrl_sel) begin
      ram_en   = 1'b1;
      ram_addr = avs_address[ADDR_W-1:0];
    end
  end

  cpu_jtag_debug_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Handshake: a CPU transfer completes on the clock edge where avs_read or avs_write is
  // high and avs_waitrequest is low; the master holds address/data/command until then.
  always_comb begin
    avs_waitrequest = 1'b0;
    if (cpu_wr)      avs_waitrequest = ~ctrl_sel & jtag_busy;
    else if (cpu_rd) avs_waitrequest = (rd_state != CPU_RD_WAIT);
  end

  assign avs_readdata  = (rd_state != CPU_RD_WAIT) ? 32'h0 :
                         rd_is_ctrl ? {30'h0, ctrl_q} : ram_rdata;
  assign dbg_mon_a_reg = mon_a_reg;
  assign dbg_rd_state  = rd_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_a_reg <= '0;
      jrd_pend  <= 1'b0;
      jrd_dly   <= 1'b0;
      jwr_pend  <= 1'b0;
      jwr_data  <= '0;
      MonDReg   <= '0;
    end else begin
      jrd_dly  <= jrd_pend;
      jwr_pend <= take_action_ocimem_b;
      jrd_pend <= (take_a & jdo[JDO_RD_BIT]) | take_n;
      if (jrd_dly) MonDReg <= ram_rdata;
      if (jwr_pend) mon_a_reg <= mon_a_reg + 1'b1;
      // A new strobe overrides the post-write increment.
      if (take_action_ocimem_b) jwr_data <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
      else if (take_a)          mon_a_reg <= jdo[JDO_ADDR_LSB +: ADDR_W];
      else if (take_n)          mon_a_reg <= mon_a_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_state   <= CPU_IDLE;
      rd_is_ctrl <= 1'b0;
      ctrl_q     <= '0;
    end else begin
      case (rd_state)
        CPU_IDLE: begin
          if (rd_issue) begin
            rd_state   <= CPU_RD_WAIT;
            rd_is_ctrl <= ctrl_sel;
            ctrl_q     <= {monitor_error, monitor_ready};
          end
        end
        CPU_RD_WAIT: rd_state <= CPU_IDLE;
        default:     rd_state <= CPU_IDLE;
      endcase
    end
  end

  // CPU set beats a same-edge JTAG clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      monitor_ready <= (monitor_ready & ~clr_mon) | set_ready;
      monitor_error <= (monitor_error & ~clr_mon) | set_error;
    end
  end

endmodule

// File: tb/tb_cpu_jtag_debug_ocimem_ctrl.sv
// Directed bench for the OCI debug memory controller: JTAG address/write/read paths,
// CPU Avalon access and arbitration, monitor flags and mid-operation reset.
module tb_cpu_jtag_debug_ocimem_ctrl;
  import cpu_jtag_debug_pkg::*;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [JDO_W-1:0]  jdo = '0;
  logic              take_action_ocimem_a = 1'b0;
  logic              take_action_ocimem_b = 1'b0;
  logic              take_no_action_ocimem_a = 1'b0;
  logic [ADDR_W:0]   avs_address = '0;
  logic              avs_read = 1'b0;
  logic              avs_write = 1'b0;
  logic [31:0]       avs_writedata = '0;
  logic [3:0]        avs_byteenable = '0;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;
  logic [ADDR_W-1:0] dbg_mon_a_reg;
  cpu_rd_state_e     dbg_rd_state;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd_data;
  int waits;

  cpu_jtag_debug_ocimem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .dbg_mon_a_reg           (dbg_mon_a_reg),
    .dbg_rd_state            (dbg_rd_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vec_cnt);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // driver tasks: called and return at a negedge
  task automatic jtag_a(input logic [ADDR_W-1:0] a, input logic rd, input logic clr);
    jdo = '0;
    jdo[JDO_ADDR_LSB +: ADDR_W] = a;
    jdo[JDO_RD_BIT]  = rd;
    jdo[JDO_CLR_BIT] = clr;
    take_action_ocimem_a = 1'b1;
    @(negedge clk);
    take_action_ocimem_a = 1'b0;
    jdo = '0;
  endtask

  task automatic jtag_b(input logic [31:0] d);
    jdo = '0;
    jdo[JDO_WDATA_MSB:JDO_WDATA_LSB] = d;
    take_action_ocimem_b = 1'b1;
    @(negedge clk);
    take_action_ocimem_b = 1'b0;
    jdo = '0;
  endtask

  task automatic jtag_n();
    take_no_action_ocimem_a = 1'b1;
    @(negedge clk);
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic jtag_rd_check(input string tag);
    repeat (JTAG_RD_LATENCY) @(negedge clk);
    chk(tag, MonDReg, exp_q.pop_front());
  endtask

  task automatic cpu_write(input logic [ADDR_W:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic also_rd, output int w);
    avs_address = a; avs_writedata = d; avs_byteenable = be;
    avs_write = 1'b1; avs_read = also_rd; w = 0;
    #1;
    while (avs_waitrequest && w < 16) begin
      @(negedge clk); #1; w++;
    end
    @(posedge clk); #1;
    avs_write = 1'b0; avs_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic cpu_read(input logic [ADDR_W:0] a, output logic [31:0] d, output int w);
    avs_address = a; avs_read = 1'b1; w = 0;
    #1;
    while (avs_waitrequest && w < 16) begin
      @(negedge clk); #1; w++;
    end
    d = avs_readdata;
    @(posedge clk); #1;
    avs_read = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_mondreg", MonDReg, 32'h0);
    chk("rst_ready", 32'(monitor_ready), 32'h0);
    chk("rst_error", 32'(monitor_error), 32'h0);
    chk("rst_readdata", avs_readdata, 32'h0);
    chk("rst_waitreq", 32'(avs_waitrequest), 32'h0);
    chk("rst_monareg", 32'(dbg_mon_a_reg), 32'h0);

    // JTAG write path
    jtag_a(8'h10, 1'b0, 1'b0);
    chk("a_load_addr", 32'(dbg_mon_a_reg), 32'h10);
    jtag_b(32'hDEADBEEF);
    @(negedge clk);
    chk("b_incr", 32'(dbg_mon_a_reg), 32'h11);
    jtag_b(32'h12345678);
    @(negedge clk);
    chk("b_incr2", 32'(dbg_mon_a_reg), 32'h12);

    // JTAG read latency, then no_action increment-and-read
    exp_q.push_back(32'hDEADBEEF);
    jtag_a(8'h10, 1'b1, 1'b0);
    @(negedge clk);
    chk("jrd_not_early", MonDReg, 32'h0);
    @(negedge clk);
    chk("jrd_a_0x10", MonDReg, exp_q.pop_front());
    chk("a_rd_addr", 32'(dbg_mon_a_reg), 32'h10);
    exp_q.push_back(32'h12345678);
    jtag_n();
    jtag_rd_check("jrd_n_0x11");
    chk("n_incr", 32'(dbg_mon_a_reg), 32'h11);

    // MonAReg wrap at all-ones
    jtag_a(8'hFF, 1'b0, 1'b0);
    jtag_b(32'h00000001);
    @(negedge clk);
    chk("wrap_addr", 32'(dbg_mon_a_reg), 32'h0);
    exp_q.push_back(32'h00000001);
    jtag_a(8'hFF, 1'b1, 1'b0);
    jtag_rd_check("jrd_0xff");

    // CPU RAM access with byte lanes
    cpu_write(9'h030, 32'hAABBCCDD, 4'hF, 1'b0, waits);
    chk("cpu_wr_waits", 32'(waits), 32'h0);
    cpu_write(9'h030, 32'h00000011, 4'b0001, 1'b0, waits);
    cpu_read(9'h030, rd_data, waits);
    chk("cpu_rd_be", rd_data, 32'hAABBCC11);
    chk("cpu_rd_waits", 32'(waits), 32'h1);
    cpu_read(9'h010, rd_data, waits);
    chk("cpu_rd_jtag_data", rd_data, 32'hDEADBEEF);

    // read and write together: write only
    cpu_write(9'h040, 32'h00000077, 4'hF, 1'b1, waits);
    chk("rw_waits", 32'(waits), 32'h0);
    cpu_read(9'h040, rd_data, waits);
    chk("rw_is_write", rd_data, 32'h00000077);

    // CPU write collides with a pending JTAG write
    jtag_a(8'h21, 1'b0, 1'b0);
    jtag_b(32'hCAFEF00D);
    cpu_write(9'h020, 32'h00000055, 4'hF, 1'b0, waits);
    chk("conflict_wr_waits", 32'(waits), 32'h1);
    chk("conflict_monareg", 32'(dbg_mon_a_reg), 32'h22);
    cpu_read(9'h020, rd_data, waits);
    chk("conflict_cpu_data", rd_data, 32'h00000055);
    exp_q.push_back(32'hCAFEF00D);
    jtag_a(8'h21, 1'b1, 1'b0);
    jtag_rd_check("conflict_jtag_data");

    // CPU read blocked by a pending JTAG read
    exp_q.push_back(32'hDEADBEEF);
    jtag_a(8'h10, 1'b1, 1'b0);
    cpu_read(9'h030, rd_data, waits);
    chk("blocked_rd_waits", 32'(waits), 32'h2);
    chk("blocked_rd_data", rd_data, 32'hAABBCC11);
    chk("blocked_jtag_data", MonDReg, exp_q.pop_front());

    // monitor control register
    cpu_write(9'h100, 32'h00000003, 4'h0, 1'b0, waits);
    chk("ctrl_set_ready", 32'(monitor_ready), 32'h1);
    chk("ctrl_set_error", 32'(monitor_error), 32'h1);
    cpu_read(9'h100, rd_data, waits);
    chk("ctrl_rd", rd_data, 32'h00000003);
    chk("ctrl_rd_waits", 32'(waits), 32'h1);
    jtag_a(8'h00, 1'b0, 1'b1);
    chk("clr_ready", 32'(monitor_ready), 32'h0);
    chk("clr_error", 32'(monitor_error), 32'h0);
    cpu_write(9'h100, 32'h00000002, 4'h0, 1'b0, waits);
    avs_address = 9'h100; avs_writedata = 32'h00000001; avs_write = 1'b1;
    jdo = '0; jdo[JDO_CLR_BIT] = 1'b1; take_action_ocimem_a = 1'b1;
    @(negedge clk);
    avs_write = 1'b0; take_action_ocimem_a = 1'b0; jdo = '0;
    chk("set_beats_clr_ready", 32'(monitor_ready), 32'h1);
    chk("clr_error_same_edge", 32'(monitor_error), 32'h0);
    cpu_read(9'h100, rd_data, waits);
    chk("ctrl_rd_after", rd_data, 32'h00000001);

    // reset with JTAG read pending and CPU read in flight
    jtag_a(8'h10, 1'b1, 1'b0);
    avs_address = 9'h030; avs_read = 1'b1;
    #1 reset_n = 1'b0;
    #1 avs_read = 1'b0;
    #1;
    chk("midrst_mondreg", MonDReg, 32'h0);
    chk("midrst_ready", 32'(monitor_ready), 32'h0);
    chk("midrst_readdata", avs_readdata, 32'h0);
    chk("midrst_waitreq", 32'(avs_waitrequest), 32'h0);
    chk("midrst_monareg", 32'(dbg_mon_a_reg), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("postrst_mondreg", MonDReg, 32'h0);
    chk("postrst_state", 32'(dbg_rd_state), 32'(CPU_IDLE));
    cpu_read(9'h010, rd_data, waits);
    chk("ram_kept", rd_data, 32'hDEADBEEF);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
